// File: rtl/num_fmt_pkg.sv
// Shared definitions for the number-format converter: mode encodings and
// the output-range limits used by the stage-2 encoder.
package num_fmt_pkg;

    localparam logic MODE_SM2TC = 1'b0;
    localparam logic MODE_TC2SM = 1'b1;

    // Largest positive magnitude representable in an out_w-bit word (either format).
    function automatic logic [63:0] pos_limit(input int out_w);
        return (64'd1 << (out_w - 1)) - 64'd1;
    endfunction

    // Largest negative magnitude representable in an out_w-bit two's-complement word.
    function automatic logic [63:0] neg_limit(input int out_w);
        return 64'd1 << (out_w - 1);
    endfunction

endpackage

// File: rtl/num_fmt_resize.sv
// Combinational stage-2 encoder: takes a sign/magnitude pair and produces the
// output word in the target format, clamping to the nearest representable value.
module num_fmt_resize
    import num_fmt_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
) (
    input  logic             i_mode,
    input  logic             i_sign,
    input  logic [IN_W-1:0]  i_mag,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    // Comparison width wide enough for both the magnitude and the limits.
    localparam int CW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

    localparam logic [CW-1:0]    POS_LIM = CW'(pos_limit(OUT_W));
    localparam logic [CW-1:0]    NEG_LIM = CW'(neg_limit(OUT_W));
    localparam logic [OUT_W-1:0] TC_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] TC_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-2:0] SM_ONES = {(OUT_W-1){1'b1}};

    logic [CW-1:0]    w_mag_ext;
    logic [CW-1:0]    w_limit;
    logic [OUT_W-1:0] w_mag_out;
    logic             w_fits;

    assign w_mag_ext = CW'(i_mag);
    // Truncation is harmless: w_mag_out is only used when the magnitude fits.
    assign w_mag_out = OUT_W'(i_mag);
    assign w_limit   = ((i_mode == MODE_SM2TC) && i_sign) ? NEG_LIM : POS_LIM;
    assign w_fits    = (w_mag_ext <= w_limit);

    always_comb begin
        o_data = '0;
        o_sat  = 1'b0;
        // A zero magnitude always encodes as plain zero, never as minus zero.
        if (i_mag != '0) begin
            if (i_mode == MODE_SM2TC) begin
                if (w_fits) begin
                    o_data = i_sign ? (~w_mag_out + OUT_W'(1)) : w_mag_out;
                end else begin
                    o_data = i_sign ? TC_MIN : TC_MAX;
                    o_sat  = 1'b1;
                end
            end else begin
                if (w_fits) begin
                    o_data = {i_sign, w_mag_out[OUT_W-2:0]};
                end else begin
                    o_data = {i_sign, SM_ONES};
                    o_sat  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/num_format_conv.sv
// Two-stage streaming sign-magnitude <-> two's-complement converter with
// independent input/output widths, saturation and a sticky saturation counter.
module num_format_conv
    import num_fmt_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_negz,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             cnt_clr
);

    // Handshake: a word moves whenever valid && ready on that side. The output
    // stage advances when it is empty or being drained; stage 1 accepts a new
    // word when it is empty or its content moves on this cycle, so a full pipe
    // with out_ready=1 streams one word per cycle without bubbles.
    logic             w_s2_adv;
    logic             w_in_xfer;
    logic             w_cnt_inc;

    logic             r_s1_valid;
    logic             r_s1_mode;
    logic             r_s1_sign;
    logic             r_s1_negz;
    logic [IN_W-1:0]  r_s1_mag;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_sat;
    logic             r_out_negz;
    logic [CNT_W-1:0] r_sat_cnt;

    logic             w_in_sign;
    logic [IN_W-1:0]  w_in_mag;
    logic             w_in_negz;
    logic [OUT_W-1:0] w_rs_data;
    logic             w_rs_sat;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer = in_valid && in_ready;

    // Stage 1: split the incoming word into sign and unsigned magnitude.
    assign w_in_sign = in_data[IN_W-1];

    always_comb begin
        w_in_mag = '0;
        if (in_mode == MODE_SM2TC) begin
            w_in_mag = {1'b0, in_data[IN_W-2:0]};
        end else begin
            w_in_mag = w_in_sign ? (~in_data + IN_W'(1)) : in_data;
        end
    end

    assign w_in_negz = (in_mode == MODE_SM2TC) && w_in_sign && (w_in_mag == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_SM2TC;
            r_s1_sign  <= 1'b0;
            r_s1_negz  <= 1'b0;
            r_s1_mag   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_xfer) begin
                r_s1_mode <= in_mode;
                r_s1_sign <= w_in_sign;
                r_s1_negz <= w_in_negz;
                r_s1_mag  <= w_in_mag;
            end
        end
    end

    num_fmt_resize #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_resize (
        .i_mode (r_s1_mode),
        .i_sign (r_s1_sign),
        .i_mag  (r_s1_mag),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    // Stage 2: output registers, held while the downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_negz  <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_rs_data;
                r_out_sat  <= w_rs_sat;
                r_out_negz <= r_s1_negz;
            end
        end
    end

    // Saturation counter: counts accepted saturated results, sticks at all-ones,
    // and a clear takes priority over a coincident count.
    assign w_cnt_inc = r_out_valid && out_ready && r_out_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (cnt_clr) begin
            r_sat_cnt <= '0;
        end else if (w_cnt_inc && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_negz  = r_out_negz;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_num_format_conv.sv
// Self-checking bench for num_format_conv: table vectors on three width
// configurations, a randomized stalled stream, counter saturation and reset flush.
module tb_num_format_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8 -> 8 instance (main streaming tests)
    logic       in_valid, in_ready, in_mode;
    logic [7:0] in_data;
    logic       out_valid, out_sat, out_negz;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [7:0] sat_cnt;
    logic       cnt_clr;

    // 8 -> 12 instance
    logic        a_in_valid, a_in_ready, a_in_mode;
    logic [7:0]  a_in_data;
    logic        a_out_valid, a_out_sat, a_out_negz;
    logic [11:0] a_out_data;
    logic [7:0]  a_sat_cnt;

    // 12 -> 8 instance
    logic        b_in_valid, b_in_ready, b_in_mode;
    logic [11:0] b_in_data;
    logic        b_out_valid, b_out_sat, b_out_negz;
    logic [7:0]  b_out_data;
    logic [7:0]  b_sat_cnt;

    logic side_ready = 1'b1;
    logic side_clr   = 1'b0;

    num_format_conv #(.IN_W(8), .OUT_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .out_negz(out_negz), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    num_format_conv #(.IN_W(8), .OUT_W(12), .CNT_W(8)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(side_ready), .out_data(a_out_data), .out_sat(a_out_sat),
        .out_negz(a_out_negz), .sat_cnt(a_sat_cnt), .cnt_clr(side_clr)
    );

    num_format_conv #(.IN_W(12), .OUT_W(8), .CNT_W(8)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(side_ready), .out_data(b_out_data), .out_sat(b_out_sat),
        .out_negz(b_out_negz), .sat_cnt(b_sat_cnt), .cnt_clr(side_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: interpret the input as a signed integer, then re-encode it in
    // the target format, clamping to the representable range. Returns {negz, sat, data}.
    function automatic logic [13:0] ref_conv(input int in_w, input int out_w,
                                             input logic mode, input logic [11:0] din);
        longint d, v, mag, half_o, full_o, res;
        logic sign, sat, negz;
        d      = longint'(din) & ((longint'(1) << in_w) - 1);
        sign   = ((d >> (in_w - 1)) & 1) != 0;
        negz   = 1'b0;
        sat    = 1'b0;
        if (mode == 1'b0) begin
            mag  = d & ((longint'(1) << (in_w - 1)) - 1);
            v    = sign ? -mag : mag;
            negz = sign && (mag == 0);
        end else begin
            v = sign ? d - (longint'(1) << in_w) : d;
        end
        half_o = longint'(1) << (out_w - 1);
        full_o = half_o * 2;
        if (mode == 1'b0) begin
            if (v > half_o - 1)   begin res = half_o - 1; sat = 1'b1; end
            else if (v < -half_o) begin res = half_o;     sat = 1'b1; end
            else                        res = (v + full_o) % full_o;
        end else begin
            if (v > half_o - 1)          begin res = half_o - 1; sat = 1'b1; end
            else if (v < -(half_o - 1))  begin res = full_o - 1; sat = 1'b1; end
            else                               res = (v < 0) ? half_o - v : v;
        end
        return {negz, sat, 12'(res)};
    endfunction

    // Scoreboard for the 8 -> 8 instance: {negz, sat, data}
    logic [9:0] exp_q[$];
    int         exp_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] held;
    int         ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        logic [13:0] r;
        logic [9:0]  e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            check("sat_cnt", sat_cnt, exp_cnt);
            check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_negz, out_sat, out_data}, held);
            end
            if (cnt_clr) exp_cnt = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {out_negz, out_sat, out_data}, 10'h3FF);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_out", {out_negz, out_sat, out_data}, e);
                    if (e[8] && !cnt_clr && exp_cnt < 255) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                r = ref_conv(8, 8, in_mode, {4'h0, in_data});
                exp_q.push_back({r[13:12], r[7:0]});
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_negz, out_sat, out_data};
        end
    end

    task automatic send0(input logic m, input logic [7:0] d);
        int waited = 0;
        in_mode  = m;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_vec(input int sel, input logic m, input logic [11:0] d,
                             output logic vld, output logic [11:0] dout,
                             output logic sat, output logic negz);
        if (sel == 0) begin
            send0(m, d[7:0]);
        end else begin
            if (sel == 1) begin
                a_in_mode = m; a_in_data = d[7:0]; a_in_valid = 1'b1;
            end else begin
                b_in_mode = m; b_in_data = d;      b_in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            a_in_valid = 1'b0;
            b_in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        case (sel)
            0:       begin vld = out_valid;   dout = {4'h0, out_data};   sat = out_sat;   negz = out_negz;   end
            1:       begin vld = a_out_valid; dout = a_out_data;         sat = a_out_sat; negz = a_out_negz; end
            default: begin vld = b_out_valid; dout = {4'h0, b_out_data}; sat = b_out_sat; negz = b_out_negz; end
        endcase
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          sel;
        logic        mode;
        logic [11:0] din;
        logic [11:0] dout;
        logic        sat;
        logic        negz;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        vld, sat, negz;
        logic [11:0] dout;
        logic [13:0] r;
        int          in_w, out_w;

        tbl[0]  = '{0, 1'b0, 12'h085, 12'h0FB, 1'b0, 1'b0};
        tbl[1]  = '{0, 1'b0, 12'h07F, 12'h07F, 1'b0, 1'b0};
        tbl[2]  = '{0, 1'b0, 12'h080, 12'h000, 1'b0, 1'b1};
        tbl[3]  = '{0, 1'b1, 12'h080, 12'h0FF, 1'b1, 1'b0};
        tbl[4]  = '{0, 1'b1, 12'h0FB, 12'h085, 1'b0, 1'b0};
        tbl[5]  = '{0, 1'b0, 12'h0FF, 12'h081, 1'b0, 1'b0};
        tbl[6]  = '{0, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0};
        tbl[7]  = '{1, 1'b0, 12'h0FF, 12'hF81, 1'b0, 1'b0};
        tbl[8]  = '{1, 1'b1, 12'h080, 12'h880, 1'b0, 1'b0};
        tbl[9]  = '{2, 1'b1, 12'hF00, 12'h0FF, 1'b1, 1'b0};
        tbl[10] = '{2, 1'b0, 12'h005, 12'h005, 1'b0, 1'b0};
        tbl[11] = '{2, 1'b0, 12'h880, 12'h080, 1'b0, 1'b0};
        tbl[12] = '{2, 1'b0, 12'h081, 12'h07F, 1'b1, 1'b0};
        tbl[13] = '{2, 1'b0, 12'h07F, 12'h07F, 1'b0, 1'b0};
        tbl[14] = '{2, 1'b0, 12'h800, 12'h000, 1'b0, 1'b1};
        tbl[15] = '{2, 1'b1, 12'h800, 12'h0FF, 1'b1, 1'b0};
        tbl[16] = '{2, 1'b1, 12'hF81, 12'h0FF, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; cnt_clr = 1'b0;
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_negz", out_negz, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed table across the three width configurations
        for (int i = 0; i < 17; i++) begin
            apply_vec(tbl[i].sel, tbl[i].mode, tbl[i].din, vld, dout, sat, negz);
            check($sformatf("tbl%0d_valid", i), vld, 1);
            check($sformatf("tbl%0d_data", i), dout, tbl[i].dout);
            check($sformatf("tbl%0d_sat", i), sat, tbl[i].sat);
            check($sformatf("tbl%0d_negz", i), negz, tbl[i].negz);
        end
        wait_drain();
        check("sat_cnt_after_table", sat_cnt, 1);

        // Random single words on the resizing instances against the model
        for (int s = 1; s <= 2; s++) begin
            in_w  = (s == 1) ? 8 : 12;
            out_w = (s == 1) ? 12 : 8;
            for (int i = 0; i < 30; i++) begin
                logic        m;
                logic [11:0] d;
                m = 1'($urandom_range(0, 1));
                d = 12'($urandom_range(0, (1 << in_w) - 1));
                r = ref_conv(in_w, out_w, m, d);
                apply_vec(s, m, d, vld, dout, sat, negz);
                check($sformatf("rnd%0d_valid", s), vld, 1);
                check($sformatf("rnd%0d_out", s), {negz, sat, dout}, r);
            end
        end

        // Back-to-back stream with randomly stalling downstream
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send0(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        ready_mode = 0;
        wait_drain();

        // Counter saturation, then clear coincident with a counting transfer
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 300; i++) send0(1'b1, 8'h80);
        wait_drain();
        check("sat_cnt_stuck", sat_cnt, 255);
        send0(1'b1, 8'h80);
        @(posedge clk);
        #1;
        check("clr_pre_valid", out_valid, 1);
        check("clr_pre_sat", out_sat, 1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_wins", sat_cnt, 0);

        // Reset with two words in flight
        send0(1'b1, 8'h80);
        wait_drain();
        check("sat_cnt_pre_rst", sat_cnt, 1);
        ready_mode = 2;
        @(posedge clk);
        #1;
        send0(1'b1, 8'h80);
        send0(1'b0, 8'h05);
        check("inflight_full", in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_cnt", sat_cnt, 0);
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_word", out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
